// File: rtl/pipe_chain_if.sv
// Handshake, hazard-query and status bundle for pipe_chain.
// master = producer/consumer side, slave = the pipeline itself.
interface pipe_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
);
    localparam int OCCW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [TAGW-1:0]  in_tag;
    logic             in_wen;
    logic [DEPTH-1:0] flush;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAGW-1:0]  out_tag;
    logic             out_wen;

    logic [TAGW-1:0]  q_tag;
    logic             q_hit;
    logic [WIDTH-1:0] q_data;
    logic             q_stall;
    logic [OCCW-1:0]  occupancy;

    modport master (
        output in_valid, in_data, in_tag, in_wen, flush, out_ready, q_tag,
        input  in_ready, out_valid, out_data, out_tag, out_wen,
               q_hit, q_data, q_stall, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_tag, in_wen, flush, out_ready, q_tag,
        output in_ready, out_valid, out_data, out_tag, out_wen,
               q_hit, q_data, q_stall, occupancy
    );
endinterface

// File: rtl/pipe_chain.sv
// Elastic DEPTH-stage pipeline with per-stage flush and destination-tag hazard query.
// Define PIPE_CHAIN_FWD_EN to forward the youngest matching payload instead of stalling.
module pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic         clk,
    input  logic         rst,
    pipe_chain_if.slave  bus
);
    localparam int OCCW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] wen_q, wen_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [TAGW-1:0]  tag_q  [DEPTH];
    logic [TAGW-1:0]  tag_d  [DEPTH];

    logic [DEPTH-1:0] ev;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] match;
    logic [OCCW-1:0]  occ;

    // A stage may load whenever any stage at or downstream of it is empty/killed,
    // or the consumer is taking the last entry; this is what compresses bubbles.
    always_comb begin
        ev  = valid_q & ~bus.flush;
        rdy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rdy[k] = bus.out_ready;
            for (int j = k; j < DEPTH; j++) begin
                if (!ev[j]) rdy[k] = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (rdy[0]) begin
            valid_d[0] = bus.in_valid;
            data_d[0]  = bus.in_data;
            tag_d[0]   = bus.in_tag;
            wen_d[0]   = bus.in_wen;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
                valid_d[k] = ev[k-1];
                data_d[k]  = data_q[k-1];
                tag_d[k]   = tag_q[k-1];
                wen_d[k]   = wen_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            wen_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
                tag_q[k]  <= tag_d[k];
            end
        end
    end

    // Tag 0 is the "no destination" register and never creates a hazard.
    always_comb begin
        match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = ev[k] & wen_q[k] & (tag_q[k] == bus.q_tag) & (bus.q_tag != '0);
        end
    end

    assign bus.q_hit = |match;

`ifdef PIPE_CHAIN_FWD_EN
    logic [WIDTH-1:0] fwd_data;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) fwd_data = data_q[k];
        end
    end

    assign bus.q_data  = fwd_data;
    assign bus.q_stall = 1'b0;
`else
    assign bus.q_data  = '0;
    assign bus.q_stall = bus.q_hit;
`endif

    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OCCW'(valid_q[k]);
        end
    end

    assign bus.occupancy = occ;
    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = ev[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.out_tag   = tag_q[DEPTH-1];
    assign bus.out_wen   = wen_q[DEPTH-1];
endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: slot-level reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_pipe_chain;
    localparam int W = 32;
    localparam int D = 4;
    localparam int T = 5;

    logic clk;
    logic rst;

    pipe_chain_if #(.WIDTH(W), .DEPTH(D), .TAGW(T)) bus ();

    pipe_chain #(.WIDTH(W), .DEPTH(D), .TAGW(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: what each slot holds.
    bit             m_v [D];
    logic [W-1:0]   m_d [D];
    logic [T-1:0]   m_t [D];
    bit             m_w [D];
    bit             n_v [D];
    logic [W-1:0]   n_d [D];
    logic [T-1:0]   n_t [D];
    bit             n_w [D];

    logic [W-1:0]   dut_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit live(input int k);
        return m_v[k] && !bus.flush[k];
    endfunction

    // An entry in slot k can move on if some slot from k onward is free or the consumer takes one.
    function automatic bit can_advance(input int k);
        if (bus.out_ready) return 1'b1;
        for (int j = k; j < D; j++) if (!live(j)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < D; k++) begin
            m_v[k] = 0; m_d[k] = '0; m_t[k] = '0; m_w[k] = 0;
        end
    endfunction

    task automatic check_all();
        int          occ;
        bit          hit;
        logic [W-1:0] yd;
        bit          found;
        occ = 0; hit = 0; yd = '0; found = 0;
        for (int k = 0; k < D; k++) begin
            if (m_v[k]) occ++;
            if (live(k) && m_w[k] && m_t[k] == bus.q_tag && bus.q_tag != 0) begin
                hit = 1;
                if (!found) begin yd = m_d[k]; found = 1; end
            end
        end
        chk("in_ready",  bus.in_ready,  can_advance(0));
        chk("out_valid", bus.out_valid, live(D-1));
        chk("occupancy", bus.occupancy, occ);
        chk("q_hit",     bus.q_hit,     hit);
`ifdef PIPE_CHAIN_FWD_EN
        chk("q_data",  bus.q_data,  yd);
        chk("q_stall", bus.q_stall, 0);
`else
        chk("q_data",  bus.q_data,  0);
        chk("q_stall", bus.q_stall, hit);
`endif
        if (live(D-1)) begin
            chk("out_data", bus.out_data, m_d[D-1]);
            chk("out_tag",  bus.out_tag,  m_t[D-1]);
            chk("out_wen",  bus.out_wen,  m_w[D-1]);
        end
        if (bus.out_valid && bus.out_ready) dut_log.push_back(bus.out_data);
    endtask

    task automatic tick_a();
        @(negedge clk);
        check_all();
        for (int k = 0; k < D; k++) begin
            n_v[k] = m_v[k]; n_d[k] = m_d[k]; n_t[k] = m_t[k]; n_w[k] = m_w[k];
        end
        if (rst) begin
            for (int k = 0; k < D; k++) begin
                n_v[k] = 0; n_d[k] = '0; n_t[k] = '0; n_w[k] = 0;
            end
        end else begin
            if (can_advance(0)) begin
                n_v[0] = bus.in_valid; n_d[0] = bus.in_data;
                n_t[0] = bus.in_tag;   n_w[0] = bus.in_wen;
            end
            for (int k = 1; k < D; k++) begin
                if (can_advance(k)) begin
                    n_v[k] = live(k-1); n_d[k] = m_d[k-1];
                    n_t[k] = m_t[k-1];  n_w[k] = m_w[k-1];
                end
            end
        end
    endtask

    task automatic tick_b();
        @(posedge clk);
        for (int k = 0; k < D; k++) begin
            m_v[k] = n_v[k]; m_d[k] = n_d[k]; m_t[k] = n_t[k]; m_w[k] = n_w[k];
        end
        #1;
    endtask

    task automatic tick();
        tick_a();
        tick_b();
    endtask

    task automatic push(input logic [W-1:0] d, input logic [T-1:0] t, input bit w);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_tag = t; bus.in_wen = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flush = '0;
        for (int i = 0; i < D + 1; i++) tick();
    endtask

    task automatic hazard_case(input bit w);
        bus.out_ready = 1'b1;
        push(32'hBB, 5'd7, w);
        push(32'h55, 5'd3, 1'b1);
        push(32'hAA, 5'd7, w);
        bus.out_ready = 1'b0;
        bus.q_tag = 5'd7;
        tick_a();
        chk("hz_hit_t7", bus.q_hit, w);
`ifdef PIPE_CHAIN_FWD_EN
        chk("hz_data_t7",  bus.q_data,  w ? 32'hAA : 32'h0);
        chk("hz_stall_t7", bus.q_stall, 0);
`else
        chk("hz_data_t7",  bus.q_data,  0);
        chk("hz_stall_t7", bus.q_stall, w);
`endif
        bus.q_tag = 5'd0;
        #1;
        chk("hz_hit_t0",   bus.q_hit,   0);
        chk("hz_stall_t0", bus.q_stall, 0);
        tick_b();
        drain();
    endtask

    logic [W-1:0] exp_seq [4];
    int           first_out;

    initial begin
        exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33; exp_seq[3] = 32'h44;
        rst = 1'b1;
        bus.in_valid = 0; bus.in_data = '0; bus.in_tag = '0; bus.in_wen = 0;
        bus.flush = '0; bus.out_ready = 0; bus.q_tag = '0;
        model_clear();
        #3;
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_q_hit",     bus.q_hit,     0);
        chk("rst_q_stall",   bus.q_stall,   0);
        chk("rst_q_data",    bus.q_data,    0);
        tick();
        rst = 1'b0;

        // Latency and throughput.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = (i < 4);
            bus.in_data  = (i < 4) ? exp_seq[i] : '0;
            bus.in_tag   = 5'd1; bus.in_wen = 1'b0;
            tick_a();
            if (i >= 4) begin
                chk("lat_valid", bus.out_valid, 1);
                chk("lat_data",  bus.out_data,  exp_seq[i-4]);
            end else begin
                chk("lat_idle", bus.out_valid, 0);
            end
            tick_b();
        end
        bus.in_valid = 1'b0;

        // Back-pressure fill and single release.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h100 + i, 5'd2, 1'b0);
        tick_a();
        chk("full_in_ready",  bus.in_ready,  0);
        chk("full_occupancy", bus.occupancy, 4);
        tick_b();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tick_a();
        chk("rel_in_ready",  bus.in_ready,  1);
        chk("rel_occupancy", bus.occupancy, 3);
        tick_b();
        drain();

        // Mid-pipe flush kills B only.
        dut_log.delete();
        bus.out_ready = 1'b1;
        push(32'hA1, 5'd4, 1'b0);
        push(32'hB2, 5'd4, 1'b0);
        push(32'hC3, 5'd4, 1'b0);
        bus.flush = 4'b0010;
        tick();
        bus.flush = '0;
        drain();
        chk("flush_count", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            chk("flush_first",  dut_log[0], 32'hA1);
            chk("flush_second", dut_log[1], 32'hC3);
        end

        hazard_case(1'b1);
        hazard_case(1'b0);

        // Asynchronous reset between edges with three entries in flight.
        bus.out_ready = 1'b1;
        push(32'h201, 5'd5, 1'b1);
        push(32'h202, 5'd5, 1'b1);
        push(32'h203, 5'd5, 1'b1);
        bus.q_tag = 5'd5;
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        chk("arst_occupancy", bus.occupancy, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_q_hit",     bus.q_hit,     0);
        chk("arst_in_ready",  bus.in_ready,  1);
        tick();
        rst = 1'b0;
        bus.q_tag = '0;
        first_out = -1;
        for (int i = 0; i < 10 && first_out < 0; i++) begin
            bus.in_valid = (i == 0);
            bus.in_data  = 32'h77;
            tick_a();
            if (bus.out_valid) begin
                first_out = i;
                chk("post_rst_data", bus.out_data, 32'h77);
            end
            tick_b();
        end
        bus.in_valid = 1'b0;
        chk("post_rst_latency", first_out, D);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = $urandom;
            bus.in_tag    = T'($urandom_range(0, 3));
            bus.in_wen    = $urandom_range(0, 1);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 7) == 0) ? D'($urandom) : '0;
            bus.q_tag     = T'($urandom_range(0, 3));
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits.
REQ-002 Parameter DEPTH, default 4, number of stages; legal range 2..8.
REQ-003 Parameter TAGW, default 5, destination-register tag width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  producer offers an entry.
REQ-007 in_ready  output  1  stage 0 can accept the offered entry.
REQ-008 in_data  input  WIDTH  payload.
REQ-009 in_tag  input  TAGW  destination register.
REQ-010 in_wen  input  1  entry writes its tag.
REQ-011 flush  input  DEPTH  bit k kills the entry held in stage k this cycle.
REQ-012 out_valid  output  1  last stage presents an entry.
REQ-013 out_ready  input  1  consumer accepts the entry.
REQ-014 out_data, out_tag, out_wen  output  WIDTH/TAGW/1  fields of the last-stage entry.
REQ-015 q_tag  input  TAGW  hazard query tag.
REQ-016 q_hit  output  1  a live in-flight entry writes q_tag.
REQ-017 q_data  output  WIDTH  forwarded payload.
REQ-018 q_stall  output  1  consumer must stall.
REQ-019 occupancy  output  clog2(DEPTH+1)  number of registered valid stages.

Function
REQ-020 Each stage k (0..DEPTH-1) SHALL hold valid_k, data, tag and wen; stage 0 is youngest, stage DEPTH-1 drives the out_* ports.
REQ-021 Live bit: ev_k = valid_k AND NOT flush[k]; killed entries never move, match or appear at the output.
REQ-022 Ready chain (combinational): r_DEPTH = out_ready; r_k = NOT ev_k OR r_(k+1); in_ready = r_0.
REQ-023 At each edge with r_k = 1, stage k SHALL load stage k-1 with valid_k <= ev_(k-1); stage 0 loads in_* with valid_0 <= in_valid.
REQ-024 At each edge with r_k = 0, stage k SHALL hold its contents unchanged.
REQ-025 A stage with r_k = 1 and no live upstream entry SHALL become invalid, so killed entries are removed.
REQ-026 Latency SHALL be DEPTH cycles, in_valid&in_ready to out_valid, with out_ready held high; throughput SHALL be one entry per cycle.
REQ-027 The pipeline SHALL be lossless and ordered, with no duplication; back-pressure SHALL compress bubbles, so stages upstream of the first bubble advance.
REQ-028 out_valid = ev_(DEPTH-1); out_valid is combinational in flush[DEPTH-1].
REQ-029 Flush with simultaneous in_valid: flush never blocks acceptance into stage 0 when r_0 = 1.
REQ-030 Match_k = ev_k AND wen_k AND tag_k == q_tag AND q_tag != 0; tag 0 never matches.
REQ-031 q_hit = OR of all Match_k, and is combinational.
REQ-032 occupancy = popcount of registered valid_k, ignoring flush.
REQ-033 Data/tag registers of invalid stages are don't-care internally, but the out_* fields SHALL still reflect the last-stage registers.

Reset
REQ-034 rst high SHALL asynchronously clear every valid_k and zero every data, tag and wen register.
REQ-035 While rst is high: out_valid=0, q_hit=0, q_data=0, q_stall=0, occupancy=0, in_ready=1.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight entries, with no partial output.

Configuration
REQ-037 Macro PIPE_CHAIN_FWD_EN defined: q_data = payload of the youngest (lowest k) matching stage, or 0 if none; q_stall = 0.
REQ-038 Macro PIPE_CHAIN_FWD_EN undefined: no forwarding mux; q_data = 0 constant; q_stall = q_hit.

Verification
REQ-039 DEPTH=4, out_ready=1, push 0x11..0x44 on consecutive cycles -> outputs 0x11..0x44 appear at cycles 4..7, in order.
REQ-040 Fill 4 entries with out_ready=0 -> in_ready=0, occupancy=4; raise out_ready for 1 cycle -> one entry leaves, in_ready=1, occupancy=3.
REQ-041 Entries A,B,C in stages 2,1,0; pulse flush=4'b0010 for one cycle -> output order A,C; B never appears.
REQ-042 FWD_EN defined; stages 0 and 2 hold tag 7 with data 0xAA and 0xBB, wen=1; q_tag=7 -> q_hit=1, q_data=0xAA, q_stall=0; q_tag=0 -> q_hit=0.
REQ-043 FWD_EN undefined, same stimulus as REQ-042 -> q_stall=1, q_data=0; set wen=0 on both stages -> q_hit=0, q_stall=0.
REQ-044 Assert rst asynchronously, between edges, with 3 valid entries -> immediately occupancy=0 and out_valid=0; after release, the next push emerges after DEPTH cycles.
